repne_cmps_sequencer: RTL and testbench

- Controls the AGEN stage-2 CMPS address datapath for REPNE CMPS.
- Splits each iteration into two memory-read micro-ops (ESI source, then EDI source) and drives the CS_IS_CMPS_FIRST_UOP_ALL, CS_IS_CMPS_SECOND_UOP_ALL and CS_REPNE_STEADY_STATE controls.
- Decrements the ECX count and stalls decode while the string operation runs.
- Ends the operation when ZF from EX is set, when the count reaches zero, or on flush.

---
 rtl/repne_cmps_sequencer.sv | 139 +++++++++++++
 tb/tb_repne_cmps_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/repne_cmps_sequencer.sv
// Sequencer for REPNE CMPS: issues the ESI/EDI read micro-op pair per iteration,
// counts ECX down, stalls decode, and retires on ZF, zero count, timeout or flush.
module repne_cmps_sequencer #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             V,
  input  logic             LD_ME,
  input  logic             IS_REPNE_CMPS,
  input  logic [CNT_W-1:0] ECX,
  input  logic             CMP_VALID,
  input  logic             CMP_ZF,
  input  logic             FLUSH,
  output logic             IS_CMPS_FIRST_UOP,
  output logic             IS_CMPS_SECOND_UOP,
  output logic             REPNE_STEADY_STATE,
  output logic             STALL_DE,
  output logic [CNT_W-1:0] ECX_OUT,
  output logic             LD_ECX,
  output logic             DONE,
  output logic             TIMEOUT_ERR
);

  localparam int unsigned TMO_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_U1       = 3'd1,
    S_U2       = 3'd2,
    S_WAIT_CMP = 3'd3,
    S_FIN      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             steady_q, steady_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_err_q, tmo_err_d;
  logic             ld_ecx_c;
  logic [CNT_W-1:0] cnt_dec_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      steady_q  <= 1'b0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      steady_q  <= steady_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  // Next-state and count/steady/timeout update; flush overrides every state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    steady_d  = steady_q;
    tmo_d     = tmo_q;
    tmo_err_d = 1'b0;
    ld_ecx_c  = 1'b0;
    cnt_dec_c = cnt_q - CNT_W'(1);

    if (FLUSH) begin
      state_d  = S_IDLE;
      steady_d = 1'b0;
      tmo_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (V && IS_REPNE_CMPS && LD_ME) begin
            if (ECX == '0) begin
              cnt_d   = '0;
              state_d = S_FIN;
            end else begin
              cnt_d    = ECX;
              steady_d = 1'b0;
              state_d  = S_U1;
            end
          end
        end
        S_U1: begin
          if (LD_ME) state_d = S_U2;
        end
        S_U2: begin
          if (LD_ME) begin
            cnt_d    = cnt_dec_c;
            ld_ecx_c = 1'b1;
            tmo_d    = '0;
            state_d  = S_WAIT_CMP;
          end
        end
        S_WAIT_CMP: begin
          if (CMP_VALID) begin
            if (CMP_ZF || (cnt_q == '0)) begin
              state_d = S_FIN;
            end else begin
              steady_d = 1'b1;
              state_d  = S_U1;
            end
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
            if (tmo_d == TMO_LAST) begin
              tmo_err_d = 1'b1;
              steady_d  = 1'b0;
              tmo_d     = '0;
              state_d   = S_IDLE;
            end
          end
        end
        S_FIN: begin
          steady_d = 1'b0;
          state_d  = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Moore decode; ECX_OUT shows the decremented value during the writeback cycle.
  assign IS_CMPS_FIRST_UOP  = (state_q == S_U1);
  assign IS_CMPS_SECOND_UOP = (state_q == S_U2);
  assign STALL_DE           = (state_q == S_U1) || (state_q == S_U2) || (state_q == S_WAIT_CMP);
  assign DONE               = (state_q == S_FIN);
  assign REPNE_STEADY_STATE = steady_q;
  assign LD_ECX             = ld_ecx_c;
  assign ECX_OUT            = ld_ecx_c ? cnt_dec_c : cnt_q;
  assign TIMEOUT_ERR        = tmo_err_q;

endmodule

// File: tb/tb_repne_cmps_sequencer.sv
// Scoreboard bench for repne_cmps_sequencer: expected ECX writebacks and steady
// flags per iteration are queued at stimulus time and popped as the DUT emits them.
module tb_repne_cmps_sequencer;

  localparam int unsigned CNT_W        = 32;
  localparam int unsigned WAIT_TIMEOUT = 15;

  logic             CLK = 1'b0;
  logic             RST, V, LD_ME, IS_REPNE_CMPS, CMP_VALID, CMP_ZF, FLUSH;
  logic [CNT_W-1:0] ECX;
  logic             IS_CMPS_FIRST_UOP, IS_CMPS_SECOND_UOP, REPNE_STEADY_STATE;
  logic             STALL_DE, LD_ECX, DONE, TIMEOUT_ERR;
  logic [CNT_W-1:0] ECX_OUT;

  int checks   = 0;
  int failures = 0;

  logic [CNT_W-1:0] exp_ecx_q[$];
  logic             exp_steady_q[$];
  int               n_first, n_second, n_ldecx, n_done, n_tmo;
  logic [CNT_W-1:0] done_ecx;
  logic             prev_first = 1'b0;
  logic             saw_second = 1'b0;

  repne_cmps_sequencer #(
    .CNT_W       (CNT_W),
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .V                 (V),
    .LD_ME             (LD_ME),
    .IS_REPNE_CMPS     (IS_REPNE_CMPS),
    .ECX               (ECX),
    .CMP_VALID         (CMP_VALID),
    .CMP_ZF            (CMP_ZF),
    .FLUSH             (FLUSH),
    .IS_CMPS_FIRST_UOP (IS_CMPS_FIRST_UOP),
    .IS_CMPS_SECOND_UOP(IS_CMPS_SECOND_UOP),
    .REPNE_STEADY_STATE(REPNE_STEADY_STATE),
    .STALL_DE          (STALL_DE),
    .ECX_OUT           (ECX_OUT),
    .LD_ECX            (LD_ECX),
    .DONE              (DONE),
    .TIMEOUT_ERR       (TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  // One clock cycle: observe at negedge (scoreboard pops), return just after posedge.
  task automatic sample();
    logic [CNT_W-1:0] e_ecx;
    logic             e_st;
    @(negedge CLK);
    if (IS_CMPS_FIRST_UOP && !prev_first) begin
      n_first++;
      checks++;
      if (exp_steady_q.size() == 0) begin
        failures++;
        $display("FAIL sb_steady: unexpected U1 entry, steady=%0b", REPNE_STEADY_STATE);
      end else begin
        e_st = exp_steady_q.pop_front();
        if (REPNE_STEADY_STATE !== e_st) begin
          failures++;
          $display("FAIL sb_steady: got %0b expected %0b", REPNE_STEADY_STATE, e_st);
        end
      end
    end
    if (IS_CMPS_SECOND_UOP) n_second++;
    if (LD_ECX) begin
      n_ldecx++;
      checks++;
      if (exp_ecx_q.size() == 0) begin
        failures++;
        $display("FAIL sb_ecx: unexpected LD_ECX, ECX_OUT=%0d", ECX_OUT);
      end else begin
        e_ecx = exp_ecx_q.pop_front();
        if (ECX_OUT !== e_ecx) begin
          failures++;
          $display("FAIL sb_ecx: got %0d expected %0d", ECX_OUT, e_ecx);
        end
      end
    end
    if (DONE) begin
      n_done++;
      done_ecx = ECX_OUT;
    end
    if (TIMEOUT_ERR) n_tmo++;
    prev_first = IS_CMPS_FIRST_UOP;
    saw_second = IS_CMPS_SECOND_UOP;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_stats();
    n_first  = 0;
    n_second = 0;
    n_ldecx  = 0;
    n_done   = 0;
    n_tmo    = 0;
    done_ecx = '0;
  endtask

  // Launch one string op with LD_ME=1; compare returns one cycle after each U2.
  task automatic run_op(input logic [CNT_W-1:0] ecx, input int zf_at, output int lat);
    int   cmp_n;
    logic want_cmp;
    cmp_n    = 0;
    want_cmp = 1'b0;
    lat      = -1;
    V = 1'b1; IS_REPNE_CMPS = 1'b1; LD_ME = 1'b1; ECX = ecx;
    CMP_VALID = 1'b0; CMP_ZF = 1'b0;
    sample();
    V = 1'b0; IS_REPNE_CMPS = 1'b0; ECX = '0;
    for (int i = 0; i < 64; i++) begin
      CMP_VALID = want_cmp;
      if (want_cmp) cmp_n++;
      CMP_ZF = want_cmp && (cmp_n == zf_at);
      sample();
      want_cmp = saw_second;
      if (n_done != 0) begin
        lat = i;
        break;
      end
    end
    CMP_VALID = 1'b0;
    CMP_ZF    = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    V = 1'($urandom); LD_ME = 1'($urandom); IS_REPNE_CMPS = 1'($urandom);
    ECX = $urandom; CMP_VALID = 1'($urandom); CMP_ZF = 1'($urandom); FLUSH = 1'($urandom);
    sample();
    sample();
    checks++; if (IS_CMPS_FIRST_UOP !== 1'b0) begin failures++; $display("FAIL reset_first: got %b expected 0", IS_CMPS_FIRST_UOP); end
    checks++; if (IS_CMPS_SECOND_UOP !== 1'b0) begin failures++; $display("FAIL reset_second: got %b expected 0", IS_CMPS_SECOND_UOP); end
    checks++; if (REPNE_STEADY_STATE !== 1'b0) begin failures++; $display("FAIL reset_steady: got %b expected 0", REPNE_STEADY_STATE); end
    checks++; if (STALL_DE !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", STALL_DE); end
    checks++; if (ECX_OUT !== '0) begin failures++; $display("FAIL reset_ecx_out: got %0d expected 0", ECX_OUT); end
    checks++; if (LD_ECX !== 1'b0) begin failures++; $display("FAIL reset_ld_ecx: got %b expected 0", LD_ECX); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", DONE); end
    checks++; if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL reset_tmo: got %b expected 0", TIMEOUT_ERR); end
    RST = 1'b0; V = 1'b0; LD_ME = 1'b0; IS_REPNE_CMPS = 1'b0; ECX = '0;
    CMP_VALID = 1'b0; CMP_ZF = 1'b0; FLUSH = 1'b0;
    sample();
  endtask

  task automatic test_no_match();
    int lat;
    clear_stats();
    exp_ecx_q.push_back(32'd2); exp_ecx_q.push_back(32'd1); exp_ecx_q.push_back(32'd0);
    exp_steady_q.push_back(1'b0); exp_steady_q.push_back(1'b1); exp_steady_q.push_back(1'b1);
    run_op(32'd3, 0, lat);
    checks++; if (lat < 0) begin failures++; $display("FAIL nomatch_done_bound: no DONE within 64 cycles"); end
    checks++; if (n_first !== 3) begin failures++; $display("FAIL nomatch_first: got %0d expected 3", n_first); end
    checks++; if (n_second !== 3) begin failures++; $display("FAIL nomatch_second: got %0d expected 3", n_second); end
    checks++; if (n_ldecx !== 3) begin failures++; $display("FAIL nomatch_ldecx: got %0d expected 3", n_ldecx); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL nomatch_done: got %0d expected 1", n_done); end
    checks++; if ((exp_ecx_q.size() + exp_steady_q.size()) !== 0) begin failures++; $display("FAIL nomatch_sb_left: got %0d entries expected 0", exp_ecx_q.size() + exp_steady_q.size()); end
    checks++; if (STALL_DE !== 1'b0) begin failures++; $display("FAIL nomatch_stall_after: got %b expected 0", STALL_DE); end
    checks++; if (REPNE_STEADY_STATE !== 1'b0) begin failures++; $display("FAIL nomatch_steady_after: got %b expected 0", REPNE_STEADY_STATE); end
  endtask

  task automatic test_zf_match();
    int lat;
    clear_stats();
    exp_ecx_q.push_back(32'd4); exp_ecx_q.push_back(32'd3);
    exp_steady_q.push_back(1'b0); exp_steady_q.push_back(1'b1);
    run_op(32'd5, 2, lat);
    checks++; if (lat < 0) begin failures++; $display("FAIL zf_done_bound: no DONE within 64 cycles"); end
    checks++; if (n_first !== 2) begin failures++; $display("FAIL zf_iters: got %0d expected 2", n_first); end
    checks++; if (n_ldecx !== 2) begin failures++; $display("FAIL zf_ldecx: got %0d expected 2", n_ldecx); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL zf_done: got %0d expected 1", n_done); end
    checks++; if (done_ecx !== 32'd3) begin failures++; $display("FAIL zf_final_ecx: got %0d expected 3", done_ecx); end
    checks++; if ((exp_ecx_q.size() + exp_steady_q.size()) !== 0) begin failures++; $display("FAIL zf_sb_left: got %0d entries expected 0", exp_ecx_q.size() + exp_steady_q.size()); end
  endtask

  task automatic test_zero_count();
    int lat;
    clear_stats();
    run_op(32'd0, 0, lat);
    checks++; if (lat !== 0) begin failures++; $display("FAIL zero_latency: got %0d expected 0", lat); end
    checks++; if ((n_first + n_second) !== 0) begin failures++; $display("FAIL zero_uops: got %0d expected 0", n_first + n_second); end
    checks++; if (n_ldecx !== 0) begin failures++; $display("FAIL zero_ldecx: got %0d expected 0", n_ldecx); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL zero_done: got %0d expected 1", n_done); end
    checks++; if (done_ecx !== 32'd0) begin failures++; $display("FAIL zero_ecx_out: got %0d expected 0", done_ecx); end
  endtask

  task automatic test_ld_me_hold();
    clear_stats();
    exp_steady_q.push_back(1'b0);
    V = 1'b1; IS_REPNE_CMPS = 1'b1; LD_ME = 1'b1; ECX = 32'd2;
    sample();
    V = 1'b0; IS_REPNE_CMPS = 1'b0; ECX = '0; LD_ME = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (IS_CMPS_FIRST_UOP !== 1'b1) begin failures++; $display("FAIL hold_first[%0d]: got %b expected 1", k, IS_CMPS_FIRST_UOP); end
      sample();
    end
    LD_ME = 1'b1;
    checks++; if (IS_CMPS_FIRST_UOP !== 1'b1) begin failures++; $display("FAIL hold_first_release: got %b expected 1", IS_CMPS_FIRST_UOP); end
    exp_ecx_q.push_back(32'd1);
    sample();
    checks++; if ({IS_CMPS_FIRST_UOP, IS_CMPS_SECOND_UOP} !== 2'b01) begin failures++; $display("FAIL hold_advance: got %b expected 01", {IS_CMPS_FIRST_UOP, IS_CMPS_SECOND_UOP}); end
    sample();
    CMP_VALID = 1'b1; CMP_ZF = 1'b1;
    sample();
    checks++; if (DONE !== 1'b1) begin failures++; $display("FAIL hold_done: got %b expected 1", DONE); end
    CMP_VALID = 1'b0; CMP_ZF = 1'b0;
    sample();
    checks++; if (n_first !== 1) begin failures++; $display("FAIL hold_entries: got %0d expected 1", n_first); end
    checks++; if ((exp_ecx_q.size() + exp_steady_q.size()) !== 0) begin failures++; $display("FAIL hold_sb_left: got %0d entries expected 0", exp_ecx_q.size() + exp_steady_q.size()); end
  endtask

  task automatic test_timeout();
    clear_stats();
    exp_ecx_q.push_back(32'd3); exp_ecx_q.push_back(32'd2);
    exp_steady_q.push_back(1'b0); exp_steady_q.push_back(1'b1);
    V = 1'b1; IS_REPNE_CMPS = 1'b1; LD_ME = 1'b1; ECX = 32'd4;
    sample();
    V = 1'b0; IS_REPNE_CMPS = 1'b0; ECX = '0;
    sample();
    sample();
    CMP_VALID = 1'b1; CMP_ZF = 1'b0;
    sample();
    CMP_VALID = 1'b0;
    sample();
    sample();
    checks++; if (REPNE_STEADY_STATE !== 1'b1) begin failures++; $display("FAIL tmo_steady_before: got %b expected 1", REPNE_STEADY_STATE); end
    for (int k = 0; k < int'(WAIT_TIMEOUT); k++) begin
      checks++;
      if ({STALL_DE, TIMEOUT_ERR} !== 2'b10) begin failures++; $display("FAIL tmo_wait[%0d]: stall/err got %b expected 10", k, {STALL_DE, TIMEOUT_ERR}); end
      sample();
    end
    checks++; if (TIMEOUT_ERR !== 1'b1) begin failures++; $display("FAIL tmo_pulse: got %b expected 1", TIMEOUT_ERR); end
    checks++; if (STALL_DE !== 1'b0) begin failures++; $display("FAIL tmo_idle: stall got %b expected 0", STALL_DE); end
    checks++; if (REPNE_STEADY_STATE !== 1'b0) begin failures++; $display("FAIL tmo_steady_after: got %b expected 0", REPNE_STEADY_STATE); end
    sample();
    checks++; if (TIMEOUT_ERR !== 1'b0) begin failures++; $display("FAIL tmo_one_cycle: got %b expected 0", TIMEOUT_ERR); end
    checks++; if (n_tmo !== 1) begin failures++; $display("FAIL tmo_count: got %0d expected 1", n_tmo); end
    checks++; if ((exp_ecx_q.size() + exp_steady_q.size()) !== 0) begin failures++; $display("FAIL tmo_sb_left: got %0d entries expected 0", exp_ecx_q.size() + exp_steady_q.size()); end
  endtask

  task automatic test_flush();
    clear_stats();
    exp_ecx_q.push_back(32'd3);
    exp_steady_q.push_back(1'b0); exp_steady_q.push_back(1'b1);
    V = 1'b1; IS_REPNE_CMPS = 1'b1; LD_ME = 1'b1; ECX = 32'd4;
    sample();
    V = 1'b0; IS_REPNE_CMPS = 1'b0; ECX = '0;
    sample();
    sample();
    CMP_VALID = 1'b1; CMP_ZF = 1'b0;
    sample();
    CMP_VALID = 1'b0;
    sample();
    checks++; if ({IS_CMPS_SECOND_UOP, REPNE_STEADY_STATE} !== 2'b11) begin failures++; $display("FAIL flush_pre: second/steady got %b expected 11", {IS_CMPS_SECOND_UOP, REPNE_STEADY_STATE}); end
    FLUSH = 1'b1;
    sample();
    FLUSH = 1'b0;
    checks++; if (STALL_DE !== 1'b0) begin failures++; $display("FAIL flush_idle: stall got %b expected 0", STALL_DE); end
    checks++; if (REPNE_STEADY_STATE !== 1'b0) begin failures++; $display("FAIL flush_steady: got %b expected 0", REPNE_STEADY_STATE); end
    checks++; if (ECX_OUT !== 32'd3) begin failures++; $display("FAIL flush_cnt_held: got %0d expected 3", ECX_OUT); end
    checks++; if (n_ldecx !== 1) begin failures++; $display("FAIL flush_ldecx: got %0d expected 1", n_ldecx); end
    sample();
    checks++; if ({IS_CMPS_FIRST_UOP, DONE} !== 2'b00) begin failures++; $display("FAIL flush_stays_idle: first/done got %b expected 00", {IS_CMPS_FIRST_UOP, DONE}); end
    checks++; if ((exp_ecx_q.size() + exp_steady_q.size()) !== 0) begin failures++; $display("FAIL flush_sb_left: got %0d entries expected 0", exp_ecx_q.size() + exp_steady_q.size()); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_no_match();
    test_zf_match();
    test_zero_count();
    test_ld_me_hold();
    test_timeout();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
